// File: rtl/vga_tile_display.sv
// Tile-based VGA scan-out engine with a double-buffered tile colour memory.
// Banks swap only at the end of the last visible line, so a displayed frame never mixes banks.
module vga_tile_display #(
   parameter int unsigned H_ACTIVE  = 640,
   parameter int unsigned H_FP      = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BP      = 48,
   parameter int unsigned V_ACTIVE  = 480,
   parameter int unsigned V_FP      = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BP      = 33,
   parameter int unsigned TILE_LOG2 = 4,
   parameter int unsigned PIX_W     = 9,
   parameter logic        SYNC_POL  = 1'b0,
   localparam int unsigned H_TILES  = H_ACTIVE >> TILE_LOG2,
   localparam int unsigned V_TILES  = V_ACTIVE >> TILE_LOG2,
   localparam int unsigned TILES    = H_TILES * V_TILES,
   localparam int unsigned ADDR_W   = $clog2(TILES)
) (
   input  logic              clk_25MHz,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [PIX_W-1:0]  wr_data,
   input  logic              swap_req,
   output logic              swap_pending,
   output logic              front_bank,
   output logic              frame_start,
   output logic              vga_hs,
   output logic              vga_vs,
   output logic              vga_de,
   output logic [PIX_W-1:0]  vga_data
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned H_W     = $clog2(H_TOTAL);
   localparam int unsigned V_W     = $clog2(V_TOTAL);

   localparam logic [H_W-1:0] H_LAST = H_W'(H_TOTAL - 1);
   localparam logic [H_W-1:0] H_VIS  = H_W'(H_ACTIVE);
   localparam logic [H_W-1:0] HS_BEG = H_W'(H_ACTIVE + H_FP);
   localparam logic [H_W-1:0] HS_END = H_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [V_W-1:0] V_LAST = V_W'(V_TOTAL - 1);
   localparam logic [V_W-1:0] V_VIS  = V_W'(V_ACTIVE);
   localparam logic [V_W-1:0] VS_BEG = V_W'(V_ACTIVE + V_FP);
   localparam logic [V_W-1:0] VS_END = V_W'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [V_W-1:0] V_SWAP = V_W'(V_ACTIVE - 1);

   typedef enum logic {
      IDLE    = 1'b0,
      PENDING = 1'b1
   } swap_state_t;

   swap_state_t       state_q, state_d;
   logic [H_W-1:0]    h_cnt_q, h_cnt_d;
   logic [V_W-1:0]    v_cnt_q, v_cnt_d;
   logic              front_bank_q, front_bank_d;
   logic              swap_pending_q, swap_pending_d;
   logic [ADDR_W-1:0] addr_s1_q, addr_s1_d;
   logic              de_s1_q, de_s1_d, hs_s1_q, hs_s1_d;
   logic              vs_s1_q, vs_s1_d, fs_s1_q, fs_s1_d;
   logic              de_q, de_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
   logic [PIX_W-1:0]  data_q, data_d;
   logic              h_last_c, v_last_c, swap_point_c, wr_ok_c;

   logic [PIX_W-1:0]  mem [2][TILES];

   // Raster counters and stage 1: tile address and timing flags for the current position.
   always_comb begin
      h_last_c = (h_cnt_q == H_LAST);
      v_last_c = (v_cnt_q == V_LAST);
      h_cnt_d  = h_last_c ? '0 : h_cnt_q + H_W'(1);
      v_cnt_d  = v_cnt_q;
      if (h_last_c) begin
         v_cnt_d = v_last_c ? '0 : v_cnt_q + V_W'(1);
      end
      de_s1_d   = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
      hs_s1_d   = ((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END)) ? SYNC_POL : ~SYNC_POL;
      vs_s1_d   = ((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END)) ? SYNC_POL : ~SYNC_POL;
      fs_s1_d   = (h_cnt_q == '0) && (v_cnt_q == '0);
      addr_s1_d = '0;
      if (de_s1_d) begin
         addr_s1_d = ADDR_W'(32'(v_cnt_q >> TILE_LOG2) * H_TILES + 32'(h_cnt_q >> TILE_LOG2));
      end
   end

   // Stage 2: front-bank read, blanked outside the active area.
   always_comb begin
      de_d   = de_s1_q;
      hs_d   = hs_s1_q;
      vs_d   = vs_s1_q;
      fs_d   = fs_s1_q;
      data_d = de_s1_q ? mem[front_bank_q][addr_s1_q] : '0;
   end

   // Swap FSM: the bank flips on the last cycle of the last visible line.
   always_comb begin
      state_d      = state_q;
      front_bank_d = front_bank_q;
      swap_point_c = h_last_c && (v_cnt_q == V_SWAP);
      case (state_q)
         IDLE: begin
            if (swap_req) state_d = PENDING;
         end
         PENDING: begin
            if (swap_point_c) begin
               state_d      = IDLE;
               front_bank_d = ~front_bank_q;
            end
         end
      endcase
      swap_pending_d = (state_d == PENDING);
   end

   assign wr_ok_c = wr_en && (32'(wr_addr) < TILES);

   // Tile memory is not reset; writes land in the bank that is not being displayed.
   always_ff @(posedge clk_25MHz) begin
      if (wr_ok_c) mem[~front_bank_q][wr_addr] <= wr_data;
   end

   always_ff @(posedge clk_25MHz or negedge rst) begin
      if (!rst) begin
         state_q        <= IDLE;
         h_cnt_q        <= '0;
         v_cnt_q        <= '0;
         front_bank_q   <= 1'b0;
         swap_pending_q <= 1'b0;
         addr_s1_q      <= '0;
         de_s1_q        <= 1'b0;
         hs_s1_q        <= ~SYNC_POL;
         vs_s1_q        <= ~SYNC_POL;
         fs_s1_q        <= 1'b0;
         de_q           <= 1'b0;
         hs_q           <= ~SYNC_POL;
         vs_q           <= ~SYNC_POL;
         fs_q           <= 1'b0;
         data_q         <= '0;
      end else begin
         state_q        <= state_d;
         h_cnt_q        <= h_cnt_d;
         v_cnt_q        <= v_cnt_d;
         front_bank_q   <= front_bank_d;
         swap_pending_q <= swap_pending_d;
         addr_s1_q      <= addr_s1_d;
         de_s1_q        <= de_s1_d;
         hs_s1_q        <= hs_s1_d;
         vs_s1_q        <= vs_s1_d;
         fs_s1_q        <= fs_s1_d;
         de_q           <= de_d;
         hs_q           <= hs_d;
         vs_q           <= vs_d;
         fs_q           <= fs_d;
         data_q         <= data_d;
      end
   end

   assign swap_pending = swap_pending_q;
   assign front_bank   = front_bank_q;
   assign frame_start  = fs_q;
   assign vga_hs       = hs_q;
   assign vga_vs       = vs_q;
   assign vga_de       = de_q;
   assign vga_data     = data_q;

endmodule

// File: tb/tb_vga_tile_display.sv
// Bench for vga_tile_display on a reduced 48x32 raster (64x38 total, 3x2 tiles of 16 px),
// with a linear-pixel-index reference model checked every cycle plus directed literal checks.
module tb_vga_tile_display;

   localparam int unsigned HA  = 48, HFP = 4, HSW = 8, HBP = 4;
   localparam int unsigned VA  = 32, VFP = 2, VSW = 2, VBP = 2;
   localparam int unsigned HT  = HA + HFP + HSW + HBP;   // 64
   localparam int unsigned VT  = VA + VFP + VSW + VBP;   // 38
   localparam int unsigned F   = HT * VT;                // 2432
   localparam int unsigned HTL = HA / 16;                // 3
   localparam int unsigned NT  = HTL * (VA / 16);        // 6

   logic       clk_25MHz = 1'b0;
   logic       rst       = 1'b1;
   logic       wr_en     = 1'b0;
   logic [2:0] wr_addr   = 3'd0;
   logic [8:0] wr_data   = 9'd0;
   logic       swap_req  = 1'b0;
   logic       swap_pending, front_bank, frame_start, vga_hs, vga_vs, vga_de;
   logic [8:0] vga_data;

   int checks   = 0;
   int failures = 0;
   bit cmp_en   = 1'b0;

   vga_tile_display #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
      .TILE_LOG2(4), .PIX_W(9), .SYNC_POL(1'b0)
   ) dut (
      .clk_25MHz(clk_25MHz), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .swap_req(swap_req), .swap_pending(swap_pending),
      .front_bank(front_bank), .frame_start(frame_start), .vga_hs(vga_hs),
      .vga_vs(vga_vs), .vga_de(vga_de), .vga_data(vga_data)
   );

   always #20 clk_25MHz = ~clk_25MHz;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: outputs after edge k show linear pixel index k-2 since reset release.
   int unsigned edges = 0;
   logic        m_front = 1'b0, m_pend = 1'b0;
   logic [8:0]  m_mem [2][NT];
   bit          m_vld [2][NT];
   logic        e_fs = 1'b0, e_hs = 1'b1, e_vs = 1'b1, e_de = 1'b0;
   logic [8:0]  e_data = 9'd0;
   bit          e_known = 1'b1;

   always @(posedge clk_25MHz or negedge rst) begin
      if (!rst) begin
         edges = 0; m_front = 1'b0; m_pend = 1'b0;
         e_fs = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_data = 9'd0; e_known = 1'b1;
      end else begin
         int unsigned h, v, q, qh, qv, tile;
         h = edges % HT;
         v = (edges / HT) % VT;
         if (edges >= 1) begin
            q  = edges - 1;
            qh = q % HT;
            qv = (q / HT) % VT;
            e_de = (qh < HA) && (qv < VA);
            e_hs = (qh >= HA + HFP && qh < HA + HFP + HSW) ? 1'b0 : 1'b1;
            e_vs = (qv >= VA + VFP && qv < VA + VFP + VSW) ? 1'b0 : 1'b1;
            e_fs = (qh == 0) && (qv == 0);
            e_data = 9'd0; e_known = 1'b1;
            if (e_de) begin
               tile    = (qv / 16) * HTL + qh / 16;
               e_data  = m_mem[m_front][tile];
               e_known = m_vld[m_front][tile];
            end
         end
         if (wr_en && int'(wr_addr) < NT) begin
            m_mem[!m_front][wr_addr] = wr_data;
            m_vld[!m_front][wr_addr] = 1'b1;
         end
         if (m_pend && h == HT - 1 && v == VA - 1) begin
            m_front = !m_front;
            m_pend  = 1'b0;
         end else if (!m_pend && swap_req) begin
            m_pend = 1'b1;
         end
         edges++;
      end
   end

   always @(negedge clk_25MHz) begin
      if (cmp_en) begin
         chk("frame_start", int'(frame_start), int'(e_fs));
         chk("vga_hs", int'(vga_hs), int'(e_hs));
         chk("vga_vs", int'(vga_vs), int'(e_vs));
         chk("vga_de", int'(vga_de), int'(e_de));
         if (e_known) chk("vga_data", int'(vga_data), int'(e_data));
         chk("front_bank", int'(front_bank), int'(m_front));
         chk("swap_pending", int'(swap_pending), int'(m_pend));
      end
   end

   task automatic wr(input int a, input int d);
      wr_en = 1'b1; wr_addr = 3'(a); wr_data = 9'(d);
      @(negedge clk_25MHz);
      wr_en = 1'b0;
   endtask

   task automatic wait_fs();
      int n = 0;
      while (frame_start !== 1'b1 && n < 3 * F) begin
         @(negedge clk_25MHz);
         n++;
      end
      chk("frame_start_seen", int'(frame_start), 1);
   endtask

   task automatic wait_toggle(input logic fb0, inout int n);
      while (front_bank == fb0 && n < 3 * F) begin
         @(negedge clk_25MHz);
         n++;
      end
   endtask

   task automatic release_reset(input string tag);
      #1 rst = 1'b1;
      @(negedge clk_25MHz);
      chk({tag, "_fs_cycle1"}, int'(frame_start), 0);
      chk({tag, "_de_cycle1"}, int'(vga_de), 0);
      @(negedge clk_25MHz);
      chk({tag, "_fs_cycle2"}, int'(frame_start), 1);
      chk({tag, "_de_cycle2"}, int'(vga_de), 1);
   endtask

   initial begin
      int n, c_fs, c_de, c_hs, c_vs, hs_first, vs_first, toggles;
      logic fb0;
      #5 rst = 1'b0;
      repeat (3) @(negedge clk_25MHz);
      cmp_en = 1'b1;

      // Reset values and first frame_start / data-enable timing
      chk("rst_front_bank", int'(front_bank), 0);
      chk("rst_swap_pending", int'(swap_pending), 0);
      chk("rst_hs", int'(vga_hs), 1);
      chk("rst_vs", int'(vga_vs), 1);
      chk("rst_data", int'(vga_data), 0);
      release_reset("rel1");

      // Two free-running frames, measured from the frame_start cycle
      c_fs = 0; c_de = 0; c_hs = 0; c_vs = 0; hs_first = -1; vs_first = -1;
      for (int i = 0; i < 2 * int'(F); i++) begin
         if (frame_start) c_fs++;
         if (vga_de) c_de++;
         if (!vga_hs) begin c_hs++; if (hs_first < 0) hs_first = i; end
         if (!vga_vs) begin c_vs++; if (vs_first < 0) vs_first = i; end
         @(negedge clk_25MHz);
      end
      chk("frames_fs_count", c_fs, 2);
      chk("frames_de_count", c_de, 3072);
      chk("frames_hs_low", c_hs, 608);
      chk("frames_vs_low", c_vs, 256);
      chk("hs_first_low", hs_first, 52);
      chk("vs_first_low", vs_first, 2176);

      // Fill back bank 1, swap, check the swap edge and corner tiles
      wr(0, 'h1C0); wr(1, 'h0AA); wr(2, 'h111); wr(3, 'h0F0); wr(4, 'h055); wr(5, 'h007);
      wait_fs();
      fb0 = front_bank; swap_req = 1'b1;
      @(negedge clk_25MHz); swap_req = 1'b0; n = 1;
      chk("pending_after_req", int'(swap_pending), 1);
      wait_toggle(fb0, n);
      chk("swap_edge_offset", n, 2046);
      chk("swap_front_bank", int'(front_bank), 1);
      chk("swap_pending_cleared", int'(swap_pending), 0);
      wait_fs();
      chk("pix_0_0", int'(vga_data), 'h1C0);
      repeat (975) @(negedge clk_25MHz);
      chk("pix_15_15", int'(vga_data), 'h1C0);
      repeat (1056) @(negedge clk_25MHz);
      chk("pix_47_31", int'(vga_data), 'h007);

      // Writes to the back bank while bank 1 is shown, plus out-of-range addresses
      wr(0, 'h038); wr(1, 'h1C7); wr(2, 'h100); wr(3, 'h002); wr(4, 'h020); wr(5, 'h155);
      wr(6, 'h1FF); wr(7, 'h1FF);
      wait_fs();
      chk("shown_unchanged", int'(vga_data), 'h1C0);

      // Three requests in one frame give exactly one swap
      repeat (100) @(negedge clk_25MHz);
      for (int k = 0; k < 3; k++) begin
         swap_req = 1'b1; @(negedge clk_25MHz); swap_req = 1'b0;
         repeat (50) @(negedge clk_25MHz);
      end
      toggles = 0; fb0 = front_bank;
      for (int i = 0; i < 2 * int'(F); i++) begin
         @(negedge clk_25MHz);
         if (front_bank != fb0) begin toggles++; fb0 = front_bank; end
      end
      chk("multi_req_toggles", toggles, 1);
      wait_fs();
      chk("bank0_pix_0_0", int'(vga_data), 'h038);

      // Request landing on the swap-point cycle is deferred a full frame
      wr(0, 'h0E3);
      wait_fs();
      fb0 = front_bank;
      repeat (2045) @(negedge clk_25MHz);
      swap_req = 1'b1; @(negedge clk_25MHz); swap_req = 1'b0; n = 2046;
      chk("deferred_front", int'(front_bank), 0);
      chk("deferred_pending", int'(swap_pending), 1);
      wait_toggle(fb0, n);
      chk("deferred_offset", n, 2046 + int'(F));
      wait_fs();
      chk("bank1_new_pix", int'(vga_data), 'h0E3);

      // Reset mid-frame at (h=30, v=20) with a swap pending
      wait_fs();
      @(negedge clk_25MHz); swap_req = 1'b1;
      @(negedge clk_25MHz); swap_req = 1'b0;
      repeat (1306) @(negedge clk_25MHz);
      chk("pre_reset_front", int'(front_bank), 1);
      chk("pre_reset_pending", int'(swap_pending), 1);
      #1 rst = 1'b0;
      #1;
      chk("mid_rst_front", int'(front_bank), 0);
      chk("mid_rst_pending", int'(swap_pending), 0);
      chk("mid_rst_de", int'(vga_de), 0);
      @(negedge clk_25MHz);
      release_reset("rel2");
      repeat (200) @(negedge clk_25MHz);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
